// File: rtl/noc_switch.sv
// noc_switch: single-input, four-output XY-routing element with a one-packet buffer
// and a valid/ready handshake on every side.
module noc_switch #(
   parameter int         WIDTH   = 33,
   parameter int         FL      = 2,
   parameter int         BL      = 1,
   parameter logic [3:0] address = 4'b0101,
   parameter logic [2:0] in_type = 3'b000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic [WIDTH-1:0] out1_data,
   output logic [WIDTH-1:0] out2_data,
   output logic [WIDTH-1:0] out3_data,
   output logic             out0_valid,
   output logic             out1_valid,
   output logic             out2_valid,
   output logic             out3_valid,
   input  logic             out0_ready,
   input  logic             out1_ready,
   input  logic             out2_ready,
   input  logic             out3_ready,
   output logic             route_err
);
   if (in_type > 3'd4 || FL < 1 || BL < 0) begin : g_bad_param
      $error("noc_switch: illegal in_type, FL or BL");
   end
   typedef enum logic [1:0] {IDLE, FWD, SEND, BACK} state_t;
   state_t           r_state, w_next;
   logic [7:0]       r_cnt, w_cnt;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_sel, w_sel;
   logic             r_err;
   logic [2:0]       w_dir;
   logic             w_uturn, w_acc, w_fire;
   logic [3:0]       w_valid, w_ready;
   // direction codes match in_type: 0=N 1=E 2=S 3=W 4=PE
   always_comb begin
      w_dir   = in_data[31:30] > address[3:2] ? 3'd1 :
                in_data[31:30] < address[3:2] ? 3'd3 :
                in_data[29:28] > address[1:0] ? 3'd0 :
                in_data[29:28] < address[1:0] ? 3'd2 : 3'd4;
      w_uturn = w_dir == in_type;
      w_sel   = (w_uturn || w_dir == 3'd4) ? 2'd3 :
                (w_dir < in_type) ? w_dir[1:0] : 2'(w_dir - 3'd1);
   end
   assign in_ready = rst_n && r_state == IDLE;
   assign w_acc    = in_valid && in_ready;
   assign w_ready  = {out3_ready, out2_ready, out1_ready, out0_ready};
   assign w_fire   = r_state == SEND && w_ready[r_sel];
   assign w_valid  = (rst_n && r_state == SEND) ? 4'b0001 << r_sel : 4'b0000;
   // counts hold the remaining cycles in FWD/BACK, so each state lasts FL-1 and BL cycles
   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      case (r_state)
         IDLE: if (w_acc) begin
            w_next = (FL == 1) ? SEND : FWD;
            w_cnt  = 8'(FL - 1);
         end
         FWD: begin
            w_cnt = r_cnt - 8'd1;
            if (r_cnt <= 8'd1) w_next = SEND;
         end
         SEND: if (w_fire) begin
            w_next = (BL == 0) ? IDLE : BACK;
            w_cnt  = 8'(BL);
         end
         default: begin
            w_cnt = r_cnt - 8'd1;
            if (r_cnt <= 8'd1) w_next = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_sel   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_err   <= w_acc && w_uturn;
         if (w_acc) begin
            r_data <= in_data;
            r_sel  <= w_sel;
         end
      end
   end
   assign out0_data  = r_data;
   assign out1_data  = r_data;
   assign out2_data  = r_data;
   assign out3_data  = r_data;
   assign out0_valid = w_valid[0];
   assign out1_valid = w_valid[1];
   assign out2_valid = w_valid[2];
   assign out3_valid = w_valid[3];
   assign route_err  = r_err;
endmodule

// File: tb/tb_noc_switch.sv
// tb_noc_switch: directed bench with one switch per input side (in_type 0..4),
// address 0101, FL=2, BL=1.
module tb_noc_switch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [32:0] in_data;
   logic        in_valid [5];
   logic        in_ready [5];
   logic        route_err [5];
   logic [3:0]  ov [5];
   logic [3:0]  ordy [5];
   logic [32:0] od [5][4];
   int          n_checks = 0;
   int          n_fail = 0;
   localparam logic [32:0] P = 33'h1_25D2E5B8;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 5; g++) begin : u
         noc_switch #(.WIDTH(33), .FL(2), .BL(1), .address(4'b0101), .in_type(3'(g))) dut (
            .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .out0_data(od[g][0]), .out1_data(od[g][1]), .out2_data(od[g][2]), .out3_data(od[g][3]),
            .out0_valid(ov[g][0]), .out1_valid(ov[g][1]), .out2_valid(ov[g][2]), .out3_valid(ov[g][3]),
            .out0_ready(ordy[g][0]), .out1_ready(ordy[g][1]), .out2_ready(ordy[g][2]), .out3_ready(ordy[g][3]),
            .route_err(route_err[g]));
      end
   endgenerate

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (in_ready[k] !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready[%0d]: got %b expected 0", k, in_ready[k]); end
         n_checks++;
         if (ov[k] !== 4'b0000) begin n_fail++; $display("FAIL rst_valid[%0d]: got %b expected 0000", k, ov[k]); end
         n_checks++;
         if (route_err[k] !== 1'b0) begin n_fail++; $display("FAIL rst_err[%0d]: got %b expected 0", k, route_err[k]); end
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (od[k][j] !== 33'h0) begin n_fail++; $display("FAIL rst_data[%0d][%0d]: got %h expected 0", k, j, od[k][j]); end
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
      end
   endtask

   task automatic test_routing();
      int          tk  [9] = '{0, 1, 2, 4, 3, 0, 0, 0, 0};
      logic [32:0] tp  [9] = '{P, P, P, P, P, 33'h0_51234567, 33'h0_91234567, 33'h0_71234567, 33'h0_41234567};
      int          tpt [9] = '{2, 2, 2, 3, 3, 3, 0, 3, 1};
      logic        te  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0]  exp_v;
      for (int i = 0; i < 9; i++) begin
         int k = tk[i];
         exp_v = 4'b0001 << tpt[i];
         @(posedge clk);
         #1 in_data = tp[i]; in_valid[k] = 1'b1;
         @(negedge clk);
         n_checks++;
         if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL route%0d_accept_ready: got %b expected 1", i, in_ready[k]); end
         @(posedge clk);
         #1 in_valid[k] = 1'b0;
         @(negedge clk);
         n_checks++;
         if (ov[k] !== 4'b0000) begin n_fail++; $display("FAIL route%0d_fwd_valid: got %b expected 0000", i, ov[k]); end
         n_checks++;
         if (route_err[k] !== te[i]) begin n_fail++; $display("FAIL route%0d_err_pulse: got %b expected %b", i, route_err[k], te[i]); end
         @(negedge clk);
         n_checks++;
         if (ov[k] !== exp_v) begin n_fail++; $display("FAIL route%0d_send_valid: got %b expected %b", i, ov[k], exp_v); end
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (od[k][j] !== tp[i]) begin n_fail++; $display("FAIL route%0d_data[%0d]: got %h expected %h", i, j, od[k][j], tp[i]); end
         end
         n_checks++;
         if (route_err[k] !== 1'b0) begin n_fail++; $display("FAIL route%0d_err_clear: got %b expected 0", i, route_err[k]); end
         n_checks++;
         if (in_ready[k] !== 1'b0) begin n_fail++; $display("FAIL route%0d_send_ready: got %b expected 0", i, in_ready[k]); end
         @(negedge clk);
         n_checks++;
         if (ov[k] !== 4'b0000 || in_ready[k] !== 1'b0) begin n_fail++; $display("FAIL route%0d_back: got valid %b ready %b expected 0000 0", i, ov[k], in_ready[k]); end
         @(negedge clk);
         n_checks++;
         if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL route%0d_idle_ready: got %b expected 1", i, in_ready[k]); end
      end
   endtask

   task automatic test_backpressure();
      ordy[0][2] = 1'b0;
      @(posedge clk);
      #1 in_data = P; in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(posedge clk);
      #1 in_data = 33'h0_41234567; in_valid[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if (ov[0] !== 4'b0100) begin n_fail++; $display("FAIL bp_valid: got %b expected 0100", ov[0]); end
         n_checks++;
         if (od[0][2] !== P) begin n_fail++; $display("FAIL bp_data: got %h expected %h", od[0][2], P); end
         n_checks++;
         if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready[0]); end
         @(posedge clk);
      end
      #1 in_valid[0] = 1'b0; ordy[0][2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 4'b0100) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0100", ov[0]); end
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 4'b0000) begin n_fail++; $display("FAIL bp_after_valid: got %b expected 0000", ov[0]); end
      @(negedge clk);
      n_checks++;
      if (in_ready[0] !== 1'b1 || ov[0] !== 4'b0000) begin n_fail++; $display("FAIL bp_idle: got ready %b valid %b expected 1 0000", in_ready[0], ov[0]); end
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 4'b0000 || od[0][2] !== P) begin n_fail++; $display("FAIL bp_single_transfer: got valid %b data %h expected 0000 %h", ov[0], od[0][2], P); end
   endtask

   task automatic test_reset_mid();
      ordy[1][2] = 1'b0;
      @(posedge clk);
      #1 in_data = P; in_valid[1] = 1'b1;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (ov[1] !== 4'b0100) begin n_fail++; $display("FAIL rm_send_valid: got %b expected 0100", ov[1]); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ov[1] !== 4'b0000 || in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL rm_assert: got valid %b ready %b expected 0000 0", ov[1], in_ready[1]); end
      @(negedge clk);
      n_checks++;
      if (ov[1] !== 4'b0000 || od[1][2] !== 33'h0 || in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL rm_cleared: got valid %b data %h ready %b expected 0000 0 0", ov[1], od[1][2], in_ready[1]); end
      @(posedge clk);
      #1 rst_n = 1'b1; ordy[1][2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL rm_release_ready: got %b expected 1", in_ready[1]); end
      @(posedge clk);
      #1 in_data = 33'h0_41234567; in_valid[1] = 1'b1;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (ov[1] !== 4'b0010 || od[1][1] !== 33'h0_41234567) begin n_fail++; $display("FAIL rm_new_pkt: got valid %b data %h expected 0010 041234567", ov[1], od[1][1]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] rh, vh;
      @(posedge clk);
      #1 in_data = P; in_valid[4] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rh[i] = in_ready[4];
         vh[i] = ov[4][3];
      end
      @(posedge clk);
      #1 in_valid[4] = 1'b0;
      n_checks++;
      if (rh !== 8'b00010001) begin n_fail++; $display("FAIL b2b_ready_pattern: got %b expected 00010001", rh); end
      n_checks++;
      if (vh !== 8'b01000100) begin n_fail++; $display("FAIL b2b_valid_pattern: got %b expected 01000100", vh); end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      in_data = '0;
      for (int k = 0; k < 5; k++) begin
         in_valid[k] = 1'b0;
         ordy[k] = 4'hF;
      end
      test_reset();
      test_routing();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
